// File: rtl/bank_biu_wb_ctrl_if.sv
// Handshake bundle for the bank write-back controller:
// HTU request, SRAM half-line beats, AXI3 AW/W/B and completion.
interface bank_biu_wb_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
);
  logic                  htu_wb_awvalid_i;
  logic                  htu_wb_awready_o;
  logic [ADDR_WIDTH-6:0] htu_wb_awaddr_i;
  logic [5:0]            htu_wb_set_way_i;

  logic                  sc_wb_valid_i;
  logic                  sc_wb_ready_o;
  logic [127:0]          sc_wb_data_i;
  logic                  sc_wb_offset_i;
  logic                  sc_wb_all_offset_i;
  logic [6:0]            sc_wb_set_way_offset_i;

  logic                  biu_axi3_awvalid_o;
  logic                  biu_axi3_awready_i;
  logic [ID_WIDTH-1:0]   biu_axi3_awid_o;
  logic [ADDR_WIDTH-1:0] biu_axi3_awaddr_o;
  logic [3:0]            biu_axi3_awlen_o;
  logic [2:0]            biu_axi3_awsize_o;
  logic [1:0]            biu_axi3_awburst_o;

  logic                  biu_axi3_wvalid_o;
  logic                  biu_axi3_wready_i;
  logic [ID_WIDTH-1:0]   biu_axi3_wid_o;
  logic [DATA_WIDTH-1:0] biu_axi3_wdata_o;
  logic [STRB_WIDTH-1:0] biu_axi3_wstrb_o;
  logic                  biu_axi3_wlast_o;

  logic                  biu_axi3_bvalid_i;
  logic                  biu_axi3_bready_o;
  logic [ID_WIDTH-1:0]   biu_axi3_bid_i;
  logic [1:0]            biu_axi3_bresp_i;

  logic                  wb_done_valid_o;
  logic [5:0]            wb_done_set_way_o;
  logic                  wb_done_err_o;

  modport master (
    input  htu_wb_awvalid_i, htu_wb_awaddr_i, htu_wb_set_way_i,
    output htu_wb_awready_o,
    input  sc_wb_valid_i, sc_wb_data_i, sc_wb_offset_i,
    input  sc_wb_all_offset_i, sc_wb_set_way_offset_i,
    output sc_wb_ready_o,
    output biu_axi3_awvalid_o, biu_axi3_awid_o, biu_axi3_awaddr_o,
    output biu_axi3_awlen_o, biu_axi3_awsize_o, biu_axi3_awburst_o,
    input  biu_axi3_awready_i,
    output biu_axi3_wvalid_o, biu_axi3_wid_o, biu_axi3_wdata_o,
    output biu_axi3_wstrb_o, biu_axi3_wlast_o,
    input  biu_axi3_wready_i,
    input  biu_axi3_bvalid_i, biu_axi3_bid_i, biu_axi3_bresp_i,
    output biu_axi3_bready_o,
    output wb_done_valid_o, wb_done_set_way_o, wb_done_err_o
  );

  modport slave (
    output htu_wb_awvalid_i, htu_wb_awaddr_i, htu_wb_set_way_i,
    input  htu_wb_awready_o,
    output sc_wb_valid_i, sc_wb_data_i, sc_wb_offset_i,
    output sc_wb_all_offset_i, sc_wb_set_way_offset_i,
    input  sc_wb_ready_o,
    input  biu_axi3_awvalid_o, biu_axi3_awid_o, biu_axi3_awaddr_o,
    input  biu_axi3_awlen_o, biu_axi3_awsize_o, biu_axi3_awburst_o,
    output biu_axi3_awready_i,
    input  biu_axi3_wvalid_o, biu_axi3_wid_o, biu_axi3_wdata_o,
    input  biu_axi3_wstrb_o, biu_axi3_wlast_o,
    output biu_axi3_wready_i,
    output biu_axi3_bvalid_i, biu_axi3_bid_i, biu_axi3_bresp_i,
    input  biu_axi3_bready_o,
    input  wb_done_valid_o, wb_done_set_way_o, wb_done_err_o
  );
endinterface

// File: rtl/bank_biu_wb_ctrl.sv
// Bank write-back controller: gathers two 128-bit halves of an evicted
// line and writes it out as one 256-bit AXI3 beat, then reports done.
module bank_biu_wb_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int ID_WIDTH   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bank_biu_wb_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, COLLECT, SEND, RESP, DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-6:0] addr_q, addr_d;
  logic [5:0]            sw_q, sw_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [1:0]            mask_q, mask_d;
  logic [1:0]            req_q, req_d;
  logic                  err_q, err_d;
  logic                  awv_q, awv_d;
  logic                  wv_q, wv_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d;
  logic                  wlast_q, wlast_d;

  logic [1:0] oh, cur, need;
  logic       aw_ok, w_ok;
  logic       unused_bits;

  assign oh    = bus.sc_wb_offset_i ? 2'b10 : 2'b01;
  assign cur   = mask_q | oh;
  // the first beat of a line decides how many halves are expected
  assign need  = (mask_q == 2'b00)
               ? (bus.sc_wb_all_offset_i ? 2'b11 : oh)
               : req_q;
  assign aw_ok = !awv_q || bus.biu_axi3_awready_i;
  assign w_ok  = !wv_q  || bus.biu_axi3_wready_i;

  assign unused_bits = ^{bus.biu_axi3_bresp_i[0],
                         bus.sc_wb_set_way_offset_i[0]};

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sw_d      = sw_q;
    buf_d     = buf_q;
    strb_d    = strb_q;
    mask_d    = mask_q;
    req_d     = req_q;
    err_d     = err_q;
    awv_d     = awv_q;
    wv_d      = wv_q;
    id_d      = id_q;
    awaddr_d  = awaddr_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wlast_d   = wlast_q;
    unique case (state_q)
      IDLE: begin
        if (bus.htu_wb_awvalid_i) begin
          addr_d  = bus.htu_wb_awaddr_i;
          sw_d    = bus.htu_wb_set_way_i;
          buf_d   = '0;
          strb_d  = '0;
          mask_d  = '0;
          req_d   = '0;
          err_d   = 1'b0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.sc_wb_valid_i) begin
          if (bus.sc_wb_offset_i) begin
            buf_d[255:128] = bus.sc_wb_data_i;
            strb_d[31:16]  = '1;
          end else begin
            buf_d[127:0]   = bus.sc_wb_data_i;
            strb_d[15:0]   = '1;
          end
          mask_d = cur;
          req_d  = need;
          if (bus.sc_wb_set_way_offset_i[6:1] != sw_q)
            err_d = 1'b1;
          if (cur == need) begin
            state_d   = SEND;
            awv_d     = 1'b1;
            wv_d      = 1'b1;
            id_d      = ID_WIDTH'(sw_q);
            awaddr_d  = {addr_q, 5'b0};
            awsize_d  = 3'b101;
            awburst_d = 2'b01;
            wlast_d   = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.biu_axi3_awready_i) awv_d = 1'b0;
        if (bus.biu_axi3_wready_i)  wv_d  = 1'b0;
        if (aw_ok && w_ok) state_d = RESP;
      end
      RESP: begin
        if (bus.biu_axi3_bvalid_i && bus.biu_axi3_bid_i == id_q) begin
          err_d   = err_q | bus.biu_axi3_bresp_i[1];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sw_q      <= '0;
      buf_q     <= '0;
      strb_q    <= '0;
      mask_q    <= '0;
      req_q     <= '0;
      err_q     <= 1'b0;
      awv_q     <= 1'b0;
      wv_q      <= 1'b0;
      id_q      <= '0;
      awaddr_q  <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sw_q      <= sw_d;
      buf_q     <= buf_d;
      strb_q    <= strb_d;
      mask_q    <= mask_d;
      req_q     <= req_d;
      err_q     <= err_d;
      awv_q     <= awv_d;
      wv_q      <= wv_d;
      id_q      <= id_d;
      awaddr_q  <= awaddr_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wlast_q   <= wlast_d;
    end
  end

  assign bus.htu_wb_awready_o   = (state_q == IDLE) && !rst_i;
  assign bus.sc_wb_ready_o      = (state_q == COLLECT);
  assign bus.biu_axi3_bready_o  = (state_q == RESP);

  assign bus.biu_axi3_awvalid_o = awv_q;
  assign bus.biu_axi3_awid_o    = id_q;
  assign bus.biu_axi3_awaddr_o  = awaddr_q;
  assign bus.biu_axi3_awlen_o   = 4'd0;
  assign bus.biu_axi3_awsize_o  = awsize_q;
  assign bus.biu_axi3_awburst_o = awburst_q;

  assign bus.biu_axi3_wvalid_o  = wv_q;
  assign bus.biu_axi3_wid_o     = id_q;
  assign bus.biu_axi3_wdata_o   = buf_q;
  assign bus.biu_axi3_wstrb_o   = strb_q;
  assign bus.biu_axi3_wlast_o   = wlast_q;

  assign bus.wb_done_valid_o    = (state_q == DONE);
  assign bus.wb_done_set_way_o  = (state_q == DONE) ? sw_q : 6'd0;
  assign bus.wb_done_err_o      = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_bank_biu_wb_ctrl.sv
// Randomized bench for bank_biu_wb_ctrl; expected line, strobes, ids,
// handshake timing and done status come from a per-line model.
module tb_bank_biu_wb_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bank_biu_wb_ctrl_if bus ();

  bank_biu_wb_ctrl dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    bus.htu_wb_awvalid_i       = 1'b0;
    bus.htu_wb_awaddr_i        = '0;
    bus.htu_wb_set_way_i       = '0;
    bus.sc_wb_valid_i          = 1'b0;
    bus.sc_wb_data_i           = '0;
    bus.sc_wb_offset_i         = 1'b0;
    bus.sc_wb_all_offset_i     = 1'b0;
    bus.sc_wb_set_way_offset_i = '0;
    bus.biu_axi3_awready_i     = 1'b0;
    bus.biu_axi3_wready_i      = 1'b0;
    bus.biu_axi3_bvalid_i      = 1'b0;
    bus.biu_axi3_bid_i         = '0;
    bus.biu_axi3_bresp_i       = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One eviction end to end. full: both halves expected; f: first offset;
  // rep: first half delivered twice; badtag: first beat carries a wrong tag;
  // gap: idle cycles before each beat; da/dw: AW/W ready delays;
  // bogus: a foreign-id B precedes the real one; br: real bresp.
  task automatic run_txn(input logic [26:0] a, input logic [5:0] sw,
                         input bit full, input bit f, input bit rep,
                         input bit badtag, input int gap,
                         input int da, input int dw, input bit bogus,
                         input logic [1:0] br, input bit lat);
    logic [127:0] half [2];
    bit           hs [2];
    bit           offs [$];
    logic [127:0] d;
    logic [255:0] ed;
    logic [31:0]  es;
    logic [7:0]   eid;
    bit           eerr;
    int           c0;
    int           kmax;
    half[0] = '0; half[1] = '0;
    hs[0] = 1'b0; hs[1] = 1'b0;
    eid  = {2'b00, sw};
    eerr = badtag;
    offs = {};
    offs.push_back(f);
    if (full && rep) offs.push_back(f);
    if (full) offs.push_back(!f);

    @(negedge clk);
    chk("req_rdy", bus.htu_wb_awready_o, 1'b1);
    bus.htu_wb_awvalid_i = 1'b1;
    bus.htu_wb_awaddr_i  = a;
    bus.htu_wb_set_way_i = sw;
    c0 = cyc;
    @(negedge clk);
    bus.htu_wb_awvalid_i = 1'b0;
    bus.htu_wb_awaddr_i  = 27'($urandom);
    bus.htu_wb_set_way_i = 6'($urandom);
    chk("req_busy", bus.htu_wb_awready_o, 1'b0);

    for (int i = 0; i < offs.size(); i++) begin
      repeat (gap) @(negedge clk);
      chk("sc_rdy", bus.sc_wb_ready_o, 1'b1);
      d = rnd128();
      bus.sc_wb_valid_i          = 1'b1;
      bus.sc_wb_data_i           = d;
      bus.sc_wb_offset_i         = offs[i];
      bus.sc_wb_all_offset_i     = full;
      bus.sc_wb_set_way_offset_i = (badtag && i == 0) ? {~sw, offs[i]}
                                                      : {sw, offs[i]};
      half[offs[i]] = d;
      hs[offs[i]]   = 1'b1;
      @(negedge clk);
      bus.sc_wb_valid_i = 1'b0;
    end

    ed = {hs[1] ? half[1] : 128'd0, hs[0] ? half[0] : 128'd0};
    es = {{16{hs[1]}}, {16{hs[0]}}};

    kmax = (da > dw) ? da : dw;
    chk("sc_idle", bus.sc_wb_ready_o, 1'b0);
    for (int k = 0; k <= kmax; k++) begin
      chk("awvalid", bus.biu_axi3_awvalid_o, k <= da);
      chk("wvalid", bus.biu_axi3_wvalid_o, k <= dw);
      chk("bready_lo", bus.biu_axi3_bready_o, 1'b0);
      if (k <= da) begin
        chk("awaddr", bus.biu_axi3_awaddr_o, {a, 5'b0});
        chk("awid", bus.biu_axi3_awid_o, eid);
        chk("awlen", bus.biu_axi3_awlen_o, 4'd0);
        chk("awsize", bus.biu_axi3_awsize_o, 3'b101);
        chk("awburst", bus.biu_axi3_awburst_o, 2'b01);
      end
      if (k <= dw) begin
        chk("wid", bus.biu_axi3_wid_o, eid);
        chk("wdata", bus.biu_axi3_wdata_o, ed);
        chk("wstrb", bus.biu_axi3_wstrb_o, es);
        chk("wlast", bus.biu_axi3_wlast_o, 1'b1);
      end
      bus.biu_axi3_awready_i = (k >= da);
      bus.biu_axi3_wready_i  = (k >= dw);
      @(negedge clk);
    end
    bus.biu_axi3_awready_i = 1'b0;
    bus.biu_axi3_wready_i  = 1'b0;

    chk("bready", bus.biu_axi3_bready_o, 1'b1);
    chk("aw_off", bus.biu_axi3_awvalid_o, 1'b0);
    bus.htu_wb_awvalid_i = 1'b1;
    chk("rsp_busy", bus.htu_wb_awready_o, 1'b0);
    if (bogus) begin
      bus.biu_axi3_bvalid_i = 1'b1;
      bus.biu_axi3_bid_i    = (sw == 6'h05) ? 8'hC5 : 8'h05;
      bus.biu_axi3_bresp_i  = 2'b10;
      @(negedge clk);
      chk("b_ign_rdy", bus.biu_axi3_bready_o, 1'b1);
      chk("b_ign_done", bus.wb_done_valid_o, 1'b0);
    end
    bus.biu_axi3_bvalid_i = 1'b1;
    bus.biu_axi3_bid_i    = eid;
    bus.biu_axi3_bresp_i  = br;
    eerr = eerr | br[1];
    @(negedge clk);
    bus.biu_axi3_bvalid_i = 1'b0;
    chk("done_v", bus.wb_done_valid_o, 1'b1);
    chk("done_sw", bus.wb_done_set_way_o, sw);
    chk("done_err", bus.wb_done_err_o, eerr);
    chk("done_busy", bus.htu_wb_awready_o, 1'b0);
    if (lat) chk("latency", cyc - c0, 5);
    bus.htu_wb_awvalid_i = 1'b0;
    @(negedge clk);
    chk("done_once", bus.wb_done_valid_o, 1'b0);
    chk("idle_rdy", bus.htu_wb_awready_o, 1'b1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.htu_wb_awvalid_i = 1'b1;
    bus.htu_wb_awaddr_i  = 27'h0ABCDEF;
    bus.htu_wb_set_way_i = 6'h1C;
    @(negedge clk);
    bus.htu_wb_awvalid_i       = 1'b0;
    bus.sc_wb_valid_i          = 1'b1;
    bus.sc_wb_data_i           = rnd128();
    bus.sc_wb_offset_i         = 1'b0;
    bus.sc_wb_all_offset_i     = 1'b0;
    bus.sc_wb_set_way_offset_i = {6'h1C, 1'b0};
    @(negedge clk);
    bus.sc_wb_valid_i = 1'b0;
    chk("rst_pre_aw", bus.biu_axi3_awvalid_o, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_aw", bus.biu_axi3_awvalid_o, 1'b0);
    chk("rst_w", bus.biu_axi3_wvalid_o, 1'b0);
    chk("rst_rdy", bus.htu_wb_awready_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_nodone", bus.wb_done_valid_o, 1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_awrdy", bus.htu_wb_awready_o, 1'b0);
    chk("rst_scrdy", bus.sc_wb_ready_o, 1'b0);
    chk("rst_awv", bus.biu_axi3_awvalid_o, 1'b0);
    chk("rst_wv", bus.biu_axi3_wvalid_o, 1'b0);
    chk("rst_bready", bus.biu_axi3_bready_o, 1'b0);
    chk("rst_done", bus.wb_done_valid_o, 1'b0);
    chk("rst_dsw", bus.wb_done_set_way_o, 6'd0);
    chk("rst_awaddr", bus.biu_axi3_awaddr_o, 32'd0);
    chk("rst_awsize", bus.biu_axi3_awsize_o, 3'd0);
    chk("rst_wdata", bus.biu_axi3_wdata_o, 256'd0);
    chk("rst_wstrb", bus.biu_axi3_wstrb_o, 32'd0);
    chk("rst_wlast", bus.biu_axi3_wlast_o, 1'b0);
    rst = 1'b0;
    #1;
    chk("rel_awrdy", bus.htu_wb_awready_o, 1'b1);

    // full line, best-case timing
    run_txn(27'h0000123, 6'h2A, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);
    // single high half
    run_txn(27'h1234567, 6'h11, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    // W early, AW held three cycles
    run_txn(27'h0000123, 6'h2A, 1, 0, 0, 0, 0, 3, 0, 0, 2'b00, 0);
    // foreign B first, then SLVERR
    run_txn(27'h0000123, 6'h2A, 1, 1, 0, 0, 1, 0, 0, 1, 2'b10, 0);
    // wrong tag on a beat
    run_txn(27'h0000123, 6'h2A, 1, 0, 0, 1, 0, 1, 2, 0, 2'b00, 0);
    // repeated half overwrites
    run_txn(27'h7FFFFFF, 6'h3F, 1, 1, 1, 0, 0, 0, 0, 0, 2'b01, 0);
    reset_mid();
    run_txn(27'h0000456, 6'h07, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1);

    for (int t = 0; t < 40; t++) begin
      bit fl;
      fl = 1'($urandom);
      run_txn(27'($urandom), 6'($urandom), fl, 1'($urandom),
              fl & 1'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 2), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom), 2'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
